// File: rtl/alu_status_reg_if.sv
// Handshake bundle between the ALU flag generator,
// the sequencer and the status register.
interface alu_status_reg_if #(
    parameter int STACK_DEPTH = 4,
    localparam int LVL_W = $clog2(STACK_DEPTH + 1)
);
    logic [4:0]       flags_in;
    logic             flags_we;
    logic [4:0]       flags_mask;
    logic [4:0]       sr_wdata;
    logic             sr_we;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic             cond_req;
    logic [3:0]       cond_sel;
    logic [4:0]       status;
    logic             cond_vld;
    logic             cond_true;
    logic [LVL_W-1:0] stk_level;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_ovf;
    logic             stk_unf;

    modport master (
        output flags_in, flags_we, flags_mask,
        output sr_wdata, sr_we,
        output push, pop, err_clr,
        output cond_req, cond_sel,
        input  status, cond_vld, cond_true,
        input  stk_level, stk_full, stk_empty,
        input  stk_ovf, stk_unf
    );

    modport slave (
        input  flags_in, flags_we, flags_mask,
        input  sr_wdata, sr_we,
        input  push, pop, err_clr,
        input  cond_req, cond_sel,
        output status, cond_vld, cond_true,
        output stk_level, stk_full, stk_empty,
        output stk_ovf, stk_unf
    );
endinterface

// File: rtl/alu_status_reg.sv
// Status register with masked ALU flag capture, interrupt
// shadow stack and a registered branch-condition evaluator.
module alu_status_reg #(
    parameter int STACK_DEPTH = 4,
    localparam int LVL_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_status_reg_if.slave      bus
);
    localparam int IDX_W =
        (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam int FZ  = 0;
    localparam int FC  = 1;
    localparam int FEQ = 2;
    localparam int FLT = 3;
    localparam int FGT = 4;

    logic [4:0]       status_q;
    logic [LVL_W-1:0] level_q;
    logic [4:0]       stack_q [STACK_DEPTH];
    logic             ovf_q;
    logic             unf_q;
    logic             vld_q;
    logic             true_q;

    logic             full;
    logic             empty;
    logic             swap;
    logic             do_push;
    logic             do_pop;
    logic             ovf_set;
    logic             unf_set;
    logic [LVL_W-1:0] lvl_m1;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [4:0]       top;
    logic             hit;

    assign full    = (level_q == LVL_W'(STACK_DEPTH));
    assign empty   = (level_q == '0);
    assign lvl_m1  = level_q - LVL_W'(1);
    assign top_idx = lvl_m1[IDX_W-1:0];
    assign top     = stack_q[top_idx];

    // push+pop on an empty stack degrades to a plain push
    assign swap    = bus.push & bus.pop & ~empty;
    assign do_push = bus.push & (~bus.pop | empty) & ~full;
    assign do_pop  = bus.pop & ~bus.push & ~empty;
    assign ovf_set = bus.push & ~bus.pop & full;
    assign unf_set = bus.pop & empty;
    assign wr_idx  = swap ? top_idx : level_q[IDX_W-1:0];

    always_comb begin
        hit = 1'b0;
        unique case (bus.cond_sel)
            4'd0:    hit = 1'b1;
            4'd1:    hit = status_q[FZ];
            4'd2:    hit = ~status_q[FZ];
            4'd3:    hit = status_q[FC];
            4'd4:    hit = ~status_q[FC];
            4'd5:    hit = status_q[FEQ];
            4'd6:    hit = ~status_q[FEQ];
            4'd7:    hit = status_q[FLT];
            4'd8:    hit = ~status_q[FLT];
            4'd9:    hit = status_q[FGT];
            4'd10:   hit = ~status_q[FGT];
            4'd11:   hit = status_q[FLT] | status_q[FEQ];
            4'd12:   hit = status_q[FGT] | status_q[FEQ];
            4'd13:   hit = status_q[FZ] & ~status_q[FC];
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            vld_q    <= 1'b0;
            true_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++)
                stack_q[i] <= '0;
        end else begin
            if (swap || do_pop)
                status_q <= top;
            else if (bus.sr_we)
                status_q <= bus.sr_wdata;
            else if (bus.flags_we)
                status_q <= (status_q & ~bus.flags_mask)
                          | (bus.flags_in & bus.flags_mask);

            if (do_push || swap)
                stack_q[wr_idx] <= status_q;

            if (do_push)
                level_q <= level_q + LVL_W'(1);
            else if (do_pop)
                level_q <= lvl_m1;

            // a fresh error outranks a same-cycle clear
            ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q <= unf_set | (unf_q & ~bus.err_clr);

            vld_q <= bus.cond_req;
            if (bus.cond_req)
                true_q <= hit;
        end
    end

    assign bus.status    = status_q;
    assign bus.cond_vld  = vld_q;
    assign bus.cond_true = true_q;
    assign bus.stk_level = level_q;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.stk_ovf   = ovf_q;
    assign bus.stk_unf   = unf_q;
endmodule

// File: tb/tb_alu_status_reg.sv
// Table-driven bench for alu_status_reg with an expectation
// queue, plus an async-reset sequence.
module tb_alu_status_reg;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0] fin;
        logic       fwe;
        logic [4:0] mask;
        logic [4:0] wd;
        logic       swe;
        logic       push;
        logic       pop;
        logic       clr;
        logic       creq;
        logic [3:0] csel;
        logic [4:0] e_st;
        logic [2:0] e_lvl;
        logic       e_ovf;
        logic       e_unf;
        logic       e_vld;
        logic       e_true;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   applied = 0;
    int   errors = 0;
    vec_t tbl [$];
    vec_t sb [$];

    alu_status_reg_if #(.STACK_DEPTH(DEPTH)) bus ();

    alu_status_reg #(.STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t row(
        input logic [4:0] fin, input logic fwe,
        input logic [4:0] mask, input logic [4:0] wd,
        input logic swe, input logic push, input logic pop,
        input logic clr, input logic creq,
        input logic [3:0] csel, input logic [4:0] e_st,
        input logic [2:0] e_lvl, input logic e_ovf,
        input logic e_unf, input logic e_vld,
        input logic e_true);
        vec_t v;
        v.fin = fin;   v.fwe = fwe;   v.mask = mask;
        v.wd = wd;     v.swe = swe;   v.push = push;
        v.pop = pop;   v.clr = clr;   v.creq = creq;
        v.csel = csel; v.e_st = e_st; v.e_lvl = e_lvl;
        v.e_ovf = e_ovf; v.e_unf = e_unf;
        v.e_vld = e_vld; v.e_true = e_true;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.flags_in   = v.fin;
        bus.flags_we   = v.fwe;
        bus.flags_mask = v.mask;
        bus.sr_wdata   = v.wd;
        bus.sr_we      = v.swe;
        bus.push       = v.push;
        bus.pop        = v.pop;
        bus.err_clr    = v.clr;
        bus.cond_req   = v.creq;
        bus.cond_sel   = v.csel;
    endtask

    task automatic check(input string name, input vec_t e);
        logic [11:0] got;
        logic [11:0] exp;
        got = {bus.status, bus.stk_level, bus.stk_full,
               bus.stk_empty, bus.stk_ovf, bus.stk_unf,
               bus.cond_vld, bus.cond_true};
        exp = {e.e_st, e.e_lvl, e.e_lvl == 3'(DEPTH),
               e.e_lvl == 3'd0, e.e_ovf, e.e_unf,
               e.e_vld, e.e_true};
        applied++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got st=%b lvl=%0d f/e/o/u/v/t=%b, want st=%b lvl=%0d f/e/o/u/v/t=%b",
                     name, got[11:7], got[6:4], got[3:0] == got[3:0] ? {got[5:0]} : 6'd0,
                     exp[11:7], exp[6:4], exp[5:0]);
        end
    endtask

    int seq [16] = '{1, 0, 1, 1, 0, 0, 1, 1,
                     0, 0, 1, 1, 0, 0, 0, 0};

    initial begin
        vec_t rv;
        drive(row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        #12;
        rv = row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
        check("reset", rv);
        rst_n = 1'b1;

        // masked update
        tbl.push_back(row(5'h1f,1,5'h05,0,0,0,0,0,0,0, 5'h05,0,0,0,0,0));
        tbl.push_back(row(5'h00,1,5'h01,0,0,0,0,0,0,0, 5'h04,0,0,0,0,0));
        // priority: pop beats sr_we beats flags_we
        tbl.push_back(row(0,0,0,5'h10,1,0,0,0,0,0, 5'h10,0,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0,1,0,0,0,0, 5'h10,1,0,0,0,0));
        tbl.push_back(row(0,0,0,5'h00,1,0,0,0,0,0, 5'h00,1,0,0,0,0));
        tbl.push_back(row(5'h1f,1,5'h1f,5'h0f,1,0,1,0,0,0, 5'h10,0,0,0,0,0));
        tbl.push_back(row(5'h00,1,5'h1f,5'h0f,1,0,0,0,0,0, 5'h0f,0,0,0,0,0));
        // fill and overflow
        tbl.push_back(row(0,0,0,5'd1,1,0,0,0,0,0, 5'd1,0,0,0,0,0));
        tbl.push_back(row(0,0,0,5'd2,1,1,0,0,0,0, 5'd2,1,0,0,0,0));
        tbl.push_back(row(0,0,0,5'd3,1,1,0,0,0,0, 5'd3,2,0,0,0,0));
        tbl.push_back(row(0,0,0,5'd4,1,1,0,0,0,0, 5'd4,3,0,0,0,0));
        tbl.push_back(row(0,0,0,5'd5,1,1,0,0,0,0, 5'd5,4,0,0,0,0));
        tbl.push_back(row(5'h1f,1,5'h02,0,0,1,0,0,0,0, 5'd7,4,1,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,0,0, 5'd4,3,1,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,0,0, 5'd3,2,1,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,0,0, 5'd2,1,1,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,0,0, 5'd1,0,1,0,0,0));
        tbl.push_back(row(0,0,0,5'h1a,1,0,1,0,0,0, 5'h1a,0,1,1,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,1,0,0, 5'h1a,0,0,0,0,0));
        // set beats clear
        tbl.push_back(row(0,0,0,0,0,0,1,1,0,0, 5'h1a,0,0,1,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,1,0,0, 5'h1a,0,0,0,0,0));
        // push+pop while empty acts as push
        tbl.push_back(row(0,0,0,5'h01,1,1,1,0,0,0, 5'h01,1,0,1,0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,0,0, 5'h1a,0,0,1,0,0));
        tbl.push_back(row(0,0,0,0,0,0,0,1,0,0, 5'h1a,0,0,0,0,0));
        // swap
        tbl.push_back(row(0,0,0,5'h03,1,0,0,0,0,0, 5'h03,0,0,0,0,0));
        tbl.push_back(row(0,0,0,5'h02,1,1,0,0,0,0, 5'h02,1,0,0,0,0));
        tbl.push_back(row(0,0,0,5'h08,1,1,0,0,0,0, 5'h08,2,0,0,0,0));
        tbl.push_back(row(5'h1f,1,5'h1f,5'h1f,1,1,1,0,0,0, 5'h02,2,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,0,0, 5'h08,1,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0,0,1,0,0,0, 5'h03,0,0,0,0,0));
        // condition sweep on LT|C
        tbl.push_back(row(0,0,0,5'h0a,1,0,0,0,0,0, 5'h0a,0,0,0,0,0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(row(0,0,0,0,0,0,0,0,1,4'(i),
                              5'h0a,0,0,0,1,1'(seq[i])));
        // in-flight result uses pre-update status
        tbl.push_back(row(5'h1f,1,5'h01,0,0,0,0,0,1,4'd1, 5'h0b,0,0,0,1,0));
        tbl.push_back(row(0,0,0,0,0,0,0,0,1,4'd1, 5'h0b,0,0,0,1,1));
        tbl.push_back(row(0,0,0,0,0,0,0,0,0,4'd2, 5'h0b,0,0,0,0,1));
        // set up level 3 with a pending cond_vld
        tbl.push_back(row(0,0,0,0,0,1,0,0,0,0, 5'h0b,1,0,0,0,1));
        tbl.push_back(row(0,0,0,0,0,1,0,0,0,0, 5'h0b,2,0,0,0,1));
        tbl.push_back(row(0,0,0,0,0,1,0,0,1,4'd14, 5'h0b,3,0,0,1,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                applied++;
                errors++;
                $display("FAIL sb_empty: got 0 entries, want 1");
            end else begin
                rv = sb.pop_front();
                check($sformatf("vec%0d", i), rv);
            end
        end

        // async reset between edges, no clock edge needed
        drive(row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        #2;
        rst_n = 1'b0;
        #1;
        rv = row(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
        check("async_rst", rv);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst", rv);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, errors);
        $finish;
    end
endmodule
